// File: rtl/mandel_pkg.sv
// Shared types and colour table for the Mandelbrot pixel dispatcher.
package mandel_pkg;

  typedef logic signed [26:0] coord_t;
  typedef logic [31:0]        iter_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_GUARD   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_ADVANCE = 3'd5,
    ST_DONE    = 3'd6
  } dispatch_state_t;

  // RGB332 palette indexed by (msb index of the iteration count) >> 2.
  localparam logic [7:0] COLOUR_LUT [0:7] = '{
    8'h03, 8'h07, 8'h1F, 8'h3C, 8'h5C, 8'hFC, 8'hF0, 8'hE0
  };

endpackage

// File: rtl/mandel_colour_map.sv
// Combinational iteration-count to RGB332 mapping: priority encoder plus palette lookup.
module mandel_colour_map
  import mandel_pkg::*;
#(
  parameter int ITER_W = 32
) (
  input  logic [ITER_W-1:0] iterations,
  input  logic [ITER_W-1:0] max_iter,
  output logic [7:0]        colour
);

  logic [31:0] msb_s;
  logic [31:0] bucket_wide_s;
  logic [2:0]  bucket_s;

  // Find the highest set bit, bucket it and fall back to black for escaped-never pixels.
  always_comb begin
    msb_s = 32'd0;
    for (int i = 0; i < ITER_W; i++) begin
      msb_s = iterations[i] ? 32'(i) : msb_s;
    end
    bucket_wide_s = msb_s >> 2;
    if (bucket_wide_s > 32'd7) begin
      bucket_s = 3'd7;
    end else begin
      bucket_s = bucket_wide_s[2:0];
    end
    if (iterations >= max_iter) begin
      colour = 8'h00;
    end else begin
      colour = COLOUR_LUT[bucket_s];
    end
  end

endmodule

// File: rtl/mandel_pixel_dispatcher.sv
// Frame walker: steps cr/ci over the grid, runs the iterator per pixel and writes RGB332 pixels.
// Defining MANDEL_CYCLE_COUNT_EN adds the frame_cycles busy-clock counter output.
module mandel_pixel_dispatcher
  import mandel_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int COORD_W = 27,
  parameter int ITER_W  = 32,
  parameter int ADDR_W  = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x_start,
  input  logic [COORD_W-1:0] y_start,
  input  logic [COORD_W-1:0] dx,
  input  logic [COORD_W-1:0] dy,
  input  logic [ITER_W-1:0]  max_iterations,
  output logic               iter_rst,
  output logic [COORD_W-1:0] iter_cr,
  output logic [COORD_W-1:0] iter_ci,
  output logic [ITER_W-1:0]  iter_max,
  input  logic [ITER_W-1:0]  iter_iterations,
  input  logic               iter_done,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [7:0]         wr_data,
  output logic               busy,
  output logic               frame_done
`ifdef MANDEL_CYCLE_COUNT_EN
  ,
  output logic [31:0]        frame_cycles
`endif
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  dispatch_state_t    state_r, state_next_s;
  logic [COL_W-1:0]   col_r;
  logic [ROW_W-1:0]   row_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [COORD_W-1:0] cr_r, ci_r, x_start_r, dx_r, dy_r;
  logic [ITER_W-1:0]  max_r;
  logic [7:0]         wr_data_r, colour_s;
  logic               iter_rst_r, wr_valid_r, busy_r, frame_done_r;
  logic               busy_next_s, last_pixel_s;

  mandel_colour_map #(.ITER_W(ITER_W)) u_colour_map (
    .iterations (iter_iterations),
    .max_iter   (max_r),
    .colour     (colour_s)
  );

  assign last_pixel_s = (col_r == COL_LAST) && (row_r == ROW_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; GUARD deliberately skips a cycle so a stale iter_done is never taken.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_LAUNCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_next_s = ST_GUARD;
      ST_GUARD:  state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (iter_done) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if (wr_valid_r && wr_ready) begin
          state_next_s = ST_ADVANCE;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      ST_ADVANCE: begin
        if (last_pixel_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_LAUNCH;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
    busy_next_s = (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);
  end

  // Registered outputs and the row/column walk over the view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_rst_r   <= 1'b0;
      wr_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      wr_data_r    <= 8'h00;
      col_r        <= '0;
      row_r        <= '0;
      addr_r       <= '0;
      cr_r         <= '0;
      ci_r         <= '0;
      x_start_r    <= '0;
      dx_r         <= '0;
      dy_r         <= '0;
      max_r        <= '0;
    end else begin
      iter_rst_r   <= (state_next_s == ST_LAUNCH);
      wr_valid_r   <= (state_next_s == ST_WRITE);
      frame_done_r <= (state_next_s == ST_DONE);
      busy_r       <= busy_next_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            x_start_r <= x_start;
            dx_r      <= dx;
            dy_r      <= dy;
            max_r     <= max_iterations;
            cr_r      <= x_start;
            ci_r      <= y_start;
            col_r     <= '0;
            row_r     <= '0;
            addr_r    <= '0;
          end
        end
        ST_WAIT: begin
          if (iter_done) begin
            wr_data_r <= colour_s;
          end
        end
        ST_ADVANCE: begin
          if (!last_pixel_s) begin
            addr_r <= addr_r + ADDR_W'(1);
            if (col_r == COL_LAST) begin
              col_r <= '0;
              row_r <= row_r + ROW_W'(1);
              cr_r  <= x_start_r;
              ci_r  <= ci_r - dy_r;
            end else begin
              col_r <= col_r + COL_W'(1);
              cr_r  <= cr_r + dx_r;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign iter_rst   = iter_rst_r;
  assign iter_cr    = cr_r;
  assign iter_ci    = ci_r;
  assign iter_max   = max_r;
  assign wr_valid   = wr_valid_r;
  assign wr_addr    = addr_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

`ifdef MANDEL_CYCLE_COUNT_EN
  logic [31:0] frame_cycles_r;

  // Busy-clock counter: cleared on start accept, saturating, holds between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cycles_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      frame_cycles_r <= 32'd0;
    end else if (busy_r && (frame_cycles_r != 32'hFFFF_FFFF)) begin
      frame_cycles_r <= frame_cycles_r + 32'd1;
    end
  end

  assign frame_cycles = frame_cycles_r;
`endif

endmodule
